// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write-back bypass and per-register
// pending-write counters that drive the decode stall.
module regfile_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] DR_in,
  input  logic [DATA_W-1:0] WB_val,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_DR,
  output logic [DATA_W-1:0] SR1_val,
  output logic [DATA_W-1:0] SR2_val,
  output logic              STALL,
  output logic              WB_ERR
);

  localparam int N = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [N];
  logic [CNT_W-1:0]  cnt  [N];
  logic              err;

  logic [N-1:0] ret;
  logic [N-1:0] busy;
  logic [N-1:0] inc;
  logic         acc;

  always_comb begin
    ret  = '0;
    busy = '0;
    for (int i = 0; i < N; i++) begin
      ret[i]  = WB_EN && (DR_in == ADDR_W'(i)) && (cnt[i] != '0);
      busy[i] = (cnt[i] - CNT_W'(ret[i])) != '0;
    end
  end

  // A write landing this cycle is bypassed, so it never stalls the reader
  always_comb begin
    STALL = busy[SR1] | busy[SR2] |
            (ISSUE_EN && (cnt[ISSUE_DR] == CNT_MAX) && !ret[ISSUE_DR]);
    acc   = ISSUE_EN && !STALL;
    inc   = '0;
    for (int i = 0; i < N; i++)
      inc[i] = acc && (ISSUE_DR == ADDR_W'(i));
  end

  always_comb begin
    SR1_val = regs[SR1];
    SR2_val = regs[SR2];
    if (WB_EN && (DR_in == SR1)) SR1_val = WB_val;
    if (WB_EN && (DR_in == SR2)) SR2_val = WB_val;
  end

  assign WB_ERR = err;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err <= 1'b0;
    end else begin
      if (WB_EN) begin
        regs[DR_in] <= WB_val;
        if (cnt[DR_in] == '0) err <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        unique case ({inc[i], ret[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table plus randomized run against a count-based model
// of the register file and its pending-write scoreboard.
module tb_regfile_scoreboard;

  logic        CLK;
  logic        RESET;
  logic        WB_EN;
  logic [2:0]  DR_in;
  logic [15:0] WB_val;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic        ISSUE_EN;
  logic [2:0]  ISSUE_DR;
  logic [15:0] SR1_val;
  logic [15:0] SR2_val;
  logic        STALL;
  logic        WB_ERR;

  regfile_scoreboard dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .WB_EN    (WB_EN),
    .DR_in    (DR_in),
    .WB_val   (WB_val),
    .SR1      (SR1),
    .SR2      (SR2),
    .ISSUE_EN (ISSUE_EN),
    .ISSUE_DR (ISSUE_DR),
    .SR1_val  (SR1_val),
    .SR2_val  (SR2_val),
    .STALL    (STALL),
    .WB_ERR   (WB_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        wb;
    logic [2:0]  dr;
    logic [15:0] val;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        iss;
    logic [2:0]  idr;
    logic        chk;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        es;
    logic        ee;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  int      m_regs [8];
  int      m_cnt  [8];
  bit      m_err;

  function automatic vec_t mk(
    logic rst, logic wb, logic [2:0] dr, logic [15:0] val,
    logic [2:0] s1, logic [2:0] s2, logic iss, logic [2:0] idr,
    logic chk, logic [15:0] e1, logic [15:0] e2,
    logic es, logic ee);
    vec_t v;
    v.rst = rst; v.wb = wb; v.dr = dr; v.val = val;
    v.s1 = s1; v.s2 = s2; v.iss = iss; v.idr = idr;
    v.chk = chk; v.e1 = e1; v.e2 = e2; v.es = es; v.ee = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RESET    = v.rst;
    WB_EN    = v.wb;
    DR_in    = v.dr;
    WB_val   = v.val;
    SR1      = v.s1;
    SR2      = v.s2;
    ISSUE_EN = v.iss;
    ISSUE_DR = v.idr;
  endtask

  task automatic check(input string nm, input vec_t v);
    n_vec++;
    if (SR1_val !== v.e1 || SR2_val !== v.e2 ||
        STALL !== v.es || WB_ERR !== v.ee) begin
      n_bad++;
      $display("FAIL %s: got sr1=%h sr2=%h stall=%b err=%b, want sr1=%h sr2=%h stall=%b err=%b",
               nm, SR1_val, SR2_val, STALL, WB_ERR,
               v.e1, v.e2, v.es, v.ee);
    end
  endtask

  function automatic bit retiring(input vec_t v, input int r);
    return v.wb && (int'(v.dr) == r) && (m_cnt[r] > 0);
  endfunction

  // Expected outputs from the model's present state
  function automatic vec_t predict(input vec_t v);
    vec_t o;
    int   left1, left2;
    o = v;
    o.e1 = (v.wb && v.dr == v.s1) ? v.val : 16'(m_regs[v.s1]);
    o.e2 = (v.wb && v.dr == v.s2) ? v.val : 16'(m_regs[v.s2]);
    left1 = m_cnt[v.s1] - (retiring(v, int'(v.s1)) ? 1 : 0);
    left2 = m_cnt[v.s2] - (retiring(v, int'(v.s2)) ? 1 : 0);
    o.es = (left1 > 0) || (left2 > 0) ||
           (v.iss && m_cnt[v.idr] >= 3 && !retiring(v, int'(v.idr)));
    o.ee = m_err;
    return o;
  endfunction

  task automatic model_step(input vec_t v, input bit stall);
    bit ret;
    if (v.rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 0;
        m_cnt[i]  = 0;
      end
      m_err = 0;
    end else begin
      if (v.wb) begin
        ret = m_cnt[v.dr] > 0;
        m_regs[v.dr] = int'(v.val);
        if (ret) m_cnt[v.dr]--;
        else     m_err = 1;
      end
      if (v.iss && !stall) m_cnt[v.idr]++;
    end
  endtask

  initial begin
    vec_t v, p;
    int   pend[$];
    n_vec = 0;
    n_bad = 0;
    RESET = 1'b1; WB_EN = 0; DR_in = 0; WB_val = 0;
    SR1 = 0; SR2 = 0; ISSUE_EN = 0; ISSUE_DR = 0;

    //       rst wb dr val       s1 s2 iss idr chk e1       e2       es ee
    tbl.push_back(mk(1,0,0,16'h0000,0,0,0,0,0,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,3,5,0,0,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,2,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,2,0,0,0,1,16'h0000,16'h0000,1,0));
    tbl.push_back(mk(0,0,0,16'h0000,2,0,0,0,1,16'h0000,16'h0000,1,0));
    tbl.push_back(mk(0,1,2,16'hBEEF,2,0,0,0,1,16'hBEEF,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,2,0,0,0,1,16'hBEEF,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,4,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,4,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,4,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,4,1,16'h0000,16'h0000,1,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,4,1,16'h0000,16'h0000,1,0));
    tbl.push_back(mk(0,1,4,16'h0444,0,0,1,4,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,4,0,0,0,1,16'h0444,16'h0000,1,0));
    tbl.push_back(mk(0,1,6,16'h0012,6,0,0,0,1,16'h0012,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,6,0,0,0,1,16'h0012,16'h0000,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,1,1,16'h0000,16'h0000,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,1,1,1,16'h0000,16'h0000,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,1,0,0,0,1,16'h0000,16'h0000,1,1));
    tbl.push_back(mk(1,1,1,16'h5555,0,0,1,1,0,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,1,4,1,1,1,16'h0000,16'h0000,0,0));
    tbl.push_back(mk(0,1,1,16'h1111,1,0,0,0,1,16'h1111,16'h0000,0,0));
    tbl.push_back(mk(0,1,7,16'hA5A5,7,7,0,0,1,16'hA5A5,16'hA5A5,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,7,1,0,0,1,16'hA5A5,16'h1111,0,1));

    @(posedge CLK);
    #1;
    foreach (tbl[k]) begin
      drive(tbl[k]);
      @(negedge CLK);
      if (tbl[k].chk) check($sformatf("tbl[%0d]", k), tbl[k]);
      @(posedge CLK);
      #1;
    end

    // Hold RESET across a write: the write must be dropped
    v = mk(1,1,3,16'h7777,0,0,1,3,0,0,0,0,0);
    drive(v);
    @(posedge CLK);
    #1;
    v = mk(0,0,0,16'h0000,3,3,0,0,1,16'h0000,16'h0000,0,0);
    drive(v);
    @(negedge CLK);
    check("rst_drop", v);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 0;
      m_cnt[i]  = 0;
    end
    m_err = 0;

    for (int n = 0; n < 3000; n++) begin
      v.rst = ($urandom_range(99) == 0);
      v.wb  = $urandom_range(1);
      v.val = 16'($urandom);
      v.s1  = 3'($urandom);
      v.s2  = 3'($urandom);
      v.iss = $urandom_range(1);
      v.idr = 3'($urandom);
      pend.delete();
      for (int r = 0; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(7) != 0)
        v.dr = 3'(pend[$urandom_range(pend.size() - 1)]);
      else
        v.dr = 3'($urandom);
      v.chk = 1;
      p = predict(v);
      drive(p);
      @(negedge CLK);
      check($sformatf("rnd[%0d]", n), p);
      model_step(p, p.es);
      @(posedge CLK);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
